// File: rtl/display_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: active-low glyphs,
// anode select patterns and the buffered display word layout.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // {g,f,e,d,c,b,a}, active-low, common-anode hex glyphs
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [3:0] DIG_OFF = 4'b1111;
    localparam logic [3:0] DIG_SEL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct packed {
        logic [3:0]  dp;
        logic [15:0] nib;
    } disp_word_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg_dec
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/display_scan_4dig.sv
// Time-multiplexed 4-digit common-anode display driver with frame-aligned
// double buffering and optional leading-zero blanking.
module display_scan_4dig
    import display_pkg::*;
#(
    parameter int unsigned DIV      = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nibble_in,
    input  logic [3:0]  dp_in,
    input  logic        load_in,
    input  logic        enable_in,
    output logic [6:0]  sseg_out,
    output logic        dp_out,
    output logic [3:0]  digit_enable,
    output logic        frame_tick_out
);

    localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic          r_live;
    logic          r_pending;
    disp_word_t    r_stage;
    disp_word_t    r_shadow;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;
    logic          r_frame;

    logic          w_tick;
    logic          w_wrap;
    logic          w_show;
    logic [1:0]    w_idx_nxt;
    disp_word_t    w_load_word;
    disp_word_t    w_shadow_nxt;
    logic [3:1]    w_zero;
    logic [3:0]    w_blank;
    logic [3:0]    w_nib_sel;
    logic          w_dp_sel;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;
    logic [3:0]    w_an_nxt;

    assign w_tick      = (r_pre == PRE_LAST);
    assign w_wrap      = w_tick && (r_idx == 2'd3);
    assign w_idx_nxt   = w_tick ? r_idx + 2'd1 : r_idx;
    assign w_load_word = {dp_in, nibble_in};

    // A load coinciding with the wrap edge bypasses the staging register.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wrap) begin
            if (load_in) begin
                w_shadow_nxt = w_load_word;
            end else if (r_pending) begin
                w_shadow_nxt = r_stage;
            end
        end
    end

    // Outputs are built from next-state idx/shadow so they stay aligned with idx.
    always_comb begin
        for (int unsigned k = 1; k < 4; k++) begin
            w_zero[k] = (w_shadow_nxt.nib[4*k +: 4] == 4'h0) && !w_shadow_nxt.dp[k];
        end
        w_blank    = '0;
        w_blank[3] = BLANK_LZ && w_zero[3];
        w_blank[2] = BLANK_LZ && (&w_zero[3:2]);
        w_blank[1] = BLANK_LZ && (&w_zero[3:1]);
        w_nib_sel  = w_shadow_nxt.nib[{w_idx_nxt, 2'b00} +: 4];
        w_dp_sel   = w_shadow_nxt.dp[w_idx_nxt];
    end

    hex7seg_dec u_dec (
        .i_nibble (w_nib_sel),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_show    = enable_in && (r_live || w_tick);
        w_an_nxt  = DIG_OFF;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (w_show) begin
            w_an_nxt = DIG_SEL[w_idx_nxt];
            if (!w_blank[w_idx_nxt]) begin
                w_seg_nxt = w_glyph;
                w_dp_nxt  = ~w_dp_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre     <= '0;
            r_idx     <= 2'd3;
            r_live    <= 1'b0;
            r_pending <= 1'b0;
            r_stage   <= '0;
            r_shadow  <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_idx   <= w_idx_nxt;
            r_frame <= w_wrap;
            // Display stays dark from reset until the first tick.
            if (w_tick) begin
                r_live <= 1'b1;
            end
            if (load_in) begin
                r_stage   <= w_load_word;
                r_pending <= 1'b1;
            end
            if (w_wrap) begin
                r_shadow  <= w_shadow_nxt;
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= DIG_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign sseg_out       = r_seg;
    assign dp_out         = r_dp;
    assign digit_enable   = r_an;
    assign frame_tick_out = r_frame;

endmodule

// File: tb/tb_display_scan_4dig.sv
// Directed scoreboard bench for display_scan_4dig: DIV=4 without and with
// leading-zero blanking, plus a DIV=1 instance sharing the same stimulus.
module tb_display_scan_4dig;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] nib;
    logic [3:0]  dpi;
    logic        load;
    logic        en;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;
    logic [3:0]  an_a, an_b, an_c;
    logic        ft_a, ft_b, ft_c;

    int n_chk = 0;
    int n_err = 0;
    int ncyc  = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg_a;
        logic [6:0] seg_b;
        logic       dp_a;
        logic       dp_b;
        logic       ft;
    } exp_t;

    exp_t q[$];

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    display_scan_4dig #(.DIV(4), .BLANK_LZ(1'b0)) dut_a (
        .clk(clk), .rst(rst), .nibble_in(nib), .dp_in(dpi), .load_in(load),
        .enable_in(en), .sseg_out(seg_a), .dp_out(dp_a), .digit_enable(an_a),
        .frame_tick_out(ft_a)
    );

    display_scan_4dig #(.DIV(4), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .nibble_in(nib), .dp_in(dpi), .load_in(load),
        .enable_in(en), .sseg_out(seg_b), .dp_out(dp_b), .digit_enable(an_b),
        .frame_tick_out(ft_b)
    );

    display_scan_4dig #(.DIV(1), .BLANK_LZ(1'b1)) dut_c (
        .clk(clk), .rst(rst), .nibble_in(nib), .dp_in(dpi), .load_in(load),
        .enable_in(en), .sseg_out(seg_c), .dp_out(dp_c), .digit_enable(an_c),
        .frame_tick_out(ft_c)
    );

    // A digit is blank when it sits above the most significant shown position.
    function automatic logic is_blank(input logic [15:0] d, input logic [3:0] p,
                                      input int k, input bit blz);
        int hi = -1;
        for (int j = 0; j < 4; j++) begin
            if (d[4*j +: 4] != 4'h0 || p[j]) hi = j;
        end
        return blz && (k > 0) && (k > hi);
    endfunction

    function automatic logic [6:0] seg_of(input logic [15:0] d, input logic [3:0] p,
                                          input int k, input bit blz);
        if (is_blank(d, p, k, blz)) return 7'h7F;
        return glyph[d[4*k +: 4]];
    endfunction

    function automatic logic dp_of(input logic [15:0] d, input logic [3:0] p,
                                   input int k, input bit blz);
        if (is_blank(d, p, k, blz)) return 1'b1;
        return ~p[k];
    endfunction

    function automatic void push_dark(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = '{an: 4'hF, seg_a: 7'h7F, seg_b: 7'h7F, dp_a: 1'b1, dp_b: 1'b1, ft: 1'b0};
            q.push_back(e);
        end
    endfunction

    // n cycles starting at digit 0 of a frame; cycles in [lo,hi) have enable low.
    function automatic void push_cycles(input logic [15:0] d, input logic [3:0] p,
                                        input int n, input int lo, input int hi);
        exp_t e;
        int   k;
        for (int c = 0; c < n; c++) begin
            k = (c / 4) % 4;
            e.ft = (c % 16 == 0);
            if (c >= lo && c < hi) begin
                e.an = 4'hF; e.seg_a = 7'h7F; e.seg_b = 7'h7F; e.dp_a = 1'b1; e.dp_b = 1'b1;
            end else begin
                e.an    = ~(4'b0001 << k);
                e.seg_a = seg_of(d, p, k, 1'b0);
                e.seg_b = seg_of(d, p, k, 1'b1);
                e.dp_a  = dp_of(d, p, k, 1'b0);
                e.dp_b  = dp_of(d, p, k, 1'b1);
            end
            q.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp_v);
        n_chk++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL %s cycle %0d: got %b, expected %b", tag, ncyc, got, exp_v);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        ncyc++;
        n_chk++;
        assert (q.size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow cycle %0d: got queue size %0d, expected nonzero", ncyc, q.size());
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("an_a",  {3'b0, an_a}, {3'b0, e.an});
            chk("an_b",  {3'b0, an_b}, {3'b0, e.an});
            chk("seg_a", seg_a, e.seg_a);
            chk("seg_b", seg_b, e.seg_b);
            chk("dp_a",  {6'b0, dp_a}, {6'b0, e.dp_a});
            chk("dp_b",  {6'b0, dp_b}, {6'b0, e.dp_b});
            chk("ft_a",  {6'b0, ft_a}, {6'b0, e.ft});
            chk("ft_b",  {6'b0, ft_b}, {6'b0, e.ft});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_load(input logic [15:0] d, input logic [3:0] p);
        nib  = d;
        dpi  = p;
        load = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", ncyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; nib = '0; dpi = '0;

        // Reset state
        push_dark(2);
        run(2);
        rst = 1'b0;

        // Reset release, two zero frames; load 1A80/0100 mid-frame in the second
        push_dark(3);
        push_cycles(16'h0000, 4'b0000, 32, 0, 0);
        push_cycles(16'h1A80, 4'b0100, 16, 0, 0);
        run(3);
        run(16);
        run(5);
        set_load(16'h1A80, 4'b0100); step(); load = 1'b0;
        run(10);
        run(16);

        // Mid-frame reloads: last one wins, current frame untouched
        push_cycles(16'h1A80, 4'b0100, 16, 0, 0);
        push_cycles(16'h00FF, 4'b0000, 16, 0, 0);
        run(3);
        set_load(16'h0001, 4'b0000); step(); load = 1'b0;
        step();
        set_load(16'h00FF, 4'b0000); step(); load = 1'b0;
        run(10);
        run(16);

        // Leading-zero blanking, with and without a dp stopping the blank run
        push_cycles(16'h00FF, 4'b0000, 16, 0, 0);
        push_cycles(16'h0005, 4'b0000, 16, 0, 0);
        run(7);
        set_load(16'h0005, 4'b0000); step(); load = 1'b0;
        run(8);
        run(2);
        set_load(16'h0005, 4'b0100); step(); load = 1'b0;
        run(13);

        // Enable low for 10 cycles spanning a frame boundary
        push_cycles(16'h0005, 4'b0100, 32, 10, 20);
        for (int c = 0; c < 32; c++) begin
            if (c == 10) en = 1'b0;
            if (c == 20) en = 1'b1;
            step();
        end

        // Stale mid-frame load, then a load on the wrap cycle takes precedence
        push_cycles(16'h0005, 4'b0100, 16, 0, 0);
        push_cycles(16'h0E9C, 4'b0010, 32, 0, 0);
        run(4);
        set_load(16'h0777, 4'b0000); step(); load = 1'b0;
        run(11);
        set_load(16'h0E9C, 4'b0010); step(); load = 1'b0;
        run(31);

        // Reset mid-frame drops pending data; DIV=1 instance rotates every cycle
        push_cycles(16'h0E9C, 4'b0010, 6, 0, 0);
        run(3);
        set_load(16'h4321, 4'b0000); step(); load = 1'b0;
        run(2);
        push_dark(1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("c_an_rst",  {3'b0, an_c}, 7'b0001111);
        chk("c_seg_rst", seg_c, 7'h7F);
        chk("c_dp_rst",  {6'b0, dp_c}, 7'd1);
        chk("c_ft_rst",  {6'b0, ft_c}, 7'd0);
        push_dark(3);
        push_cycles(16'h0000, 4'b0000, 16, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("c_an",  {3'b0, an_c}, {3'b0, ~(4'b0001 << (i % 4))});
            chk("c_seg", seg_c, (i % 4 == 0) ? 7'h40 : 7'h7F);
            chk("c_dp",  {6'b0, dp_c}, 7'd1);
            chk("c_ft",  {6'b0, ft_c}, {6'b0, (i % 4 == 0)});
        end
        run(14);

        n_chk++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_leftover: got %0d entries, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_4dig.md
# display_scan_4dig

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the counter stages and takes up to four 4-bit values plus decimal points. Values are double-buffered so that a change is only applied at a frame boundary. It scans one digit at a time at a programmable refresh rate, with hex glyphs (0–F) and optional leading-zero blanking.

## Interface
- `DIV`, default 50000: clock cycles each digit stays lit; must be ≥ 1.
- `BLANK_LZ`, default 1: when 1, leading zeros are blanked; when 0, all four digits are always shown.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `nibble_in`  in  16  display data: [3:0] = digit 0 (rightmost) … [15:12] = digit 3.
- `dp_in`  in  4  decimal point request per digit; bit k belongs to digit k.
- `load_in`  in  1  capture `nibble_in`/`dp_in` into the staging register this cycle.
- `enable_in`  in  1  0 = display dark; scanning continues.
- `sseg_out`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_out`  out  1  decimal point, active-low.
- `digit_enable`  out  4  anode select, active-low, at most one bit low.
- `frame_tick_out`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- **Prescaler:** `pre` counts 0 to DIV−1 and wraps. `tick` = (`pre` == DIV−1).
- **Digit index:** `idx` is 2 bits and advances on each `tick`, wrapping 3→0.
- **Wrap edge:** the edge where `idx` goes 3→0 is the frame boundary; `frame_tick_out` is high for the cycle after it.
- **Staging:** on any cycle with `load_in`=1, `stage` ← {`dp_in`,`nibble_in`} and `pending` ← 1. When several loads occur, the last one wins.
- **Shadow update:** on the wrap edge, if `load_in`=1 that same cycle, `shadow` ← {`dp_in`,`nibble_in`} (bypass). Otherwise, if `pending`=1, `shadow` ← `stage`. `pending` is cleared in both cases.
- **Mid-frame loads:** loads outside the wrap edge never alter the frame in progress.
- **Decode:** hex glyphs, active-low. Reference values: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- **Leading-zero blanking (`BLANK_LZ`=1):** digit k ∈ {3,2,1} is blank when its nibble and every higher nibble are 0 and its dp bit is 0. Digit 0 is never blanked. A blank digit drives `sseg_out`=1111111 and `dp_out`=1, but its anode is still selected.
- **Disabled (`enable_in`=0):** `digit_enable`=1111, `sseg_out`=1111111 and `dp_out`=1. The prescaler, `idx`, the staging/shadow logic and `frame_tick_out` keep running.

## Timing
- **Reset values:**
  - `pre`=0 and `idx`=3.
  - `shadow`, `stage` and `pending` all 0.
  - `digit_enable`=1111, `sseg_out`=1111111, `dp_out`=1, `frame_tick_out`=0.
- **Registered outputs:** all outputs are registered.
- **Output update:** `digit_enable`, `sseg_out` and `dp_out` update on the same edge as `idx`, from the next-state `idx` and `shadow`, so they always match the digit currently indexed.
- **First frame:** from the cycle after reset release, the first `tick` arrives DIV cycles later. That wrap edge lights digit 0 and raises `frame_tick_out` for one cycle.
- **Output period:** each digit is lit for exactly DIV cycles; one frame is 4·DIV cycles.
- **Load latency:** a load becomes visible at the next wrap edge, i.e. between 1 and 4·DIV cycles later.
- **Reset mid-frame:** takes effect on the next edge. Pending data is lost and the display goes dark until the first tick.
- **`enable_in` change:** takes effect on the next edge, whether or not a `tick` occurs.
- **DIV=1:** `tick` is high every cycle and `idx` advances every cycle.

## Structure
- **Shared package `display_pkg`:**
  - segment constants: `SEG_BLANK`, and the 16-entry glyph table `SEG_HEX[0:15]`;
  - digit-select constants: `DIG_OFF`=4'b1111 and the one-cold patterns per index.
- **Sub-module `hex7seg_dec`:** combinational, 4-bit in, 7-bit active-low out. It is instantiated once on the selected nibble.
- **Top-level contents:** the prescaler, index, staging/shadow registers, blanking logic and output registers all stay in the top module.

## Test plan
All scenarios use DIV=4 unless stated.
1. **Reset release:** outputs dark for 4 cycles. Then `digit_enable`=1110 and `frame_tick_out`=1 for one cycle. Digits then rotate 1101, 1011, 0111, 1110, each for 4 cycles.
2. **Load on wrap:** with `BLANK_LZ`=0, pulse `load_in` with `nibble_in`=16'h1A80 and `dp_in`=4'b0100. At the next wrap, the expected sequence is:
   - digit 0: `sseg_out`=1000000 (0);
   - digit 1: `sseg_out`=0000000 (8);
   - digit 2: `sseg_out`=0001000 (A) with `dp_out`=0;
   - digit 3: `sseg_out`=1111001 (1).
3. **Mid-frame reload:** load 16'h0001, then load 16'h00FF two cycles later, both mid-frame. The current frame is unchanged. The next frame shows FF only; 0001 never appears.
4. **Blanking:** with `BLANK_LZ`=1, load 16'h0005 with `dp_in`=4'b0000: digits 3–1 blank and digit 0 shows 5. Then load 16'h0005 with `dp_in`=4'b0100: digit 2 shows 0 with dp lit, and digits 1 and 0 are shown.
5. **Enable low:** drive `enable_in`=0 for 10 cycles. All outputs are dark but `frame_tick_out` still pulses every 16 cycles. On re-enable, the correct digit for the current `idx` lights on the next edge.
6. **Simultaneous events and DIV=1:** assert `load_in` on the wrap cycle; the new data is displayed starting with digit 0 of that frame. Assert `rst` mid-frame; outputs go dark on the next edge. With DIV=1, digits rotate every cycle.
